// File: rtl/falafel_output_arbiter_if.sv
// Response-side bus of the output arbiter: FWFT response FIFO head,
// per-queue valid/ready response channels and the bad-ID counter.
interface falafel_output_arbiter_if #(
    parameter int NUM_HEADER_QUEUES = 1,
    parameter int NUM_ALLOC_QUEUES  = 1,
    parameter int DATA_W            = 32,
    parameter int MSG_ID_SIZE       = 4
);
    localparam int NUM_RESP_QUEUES = NUM_HEADER_QUEUES + NUM_ALLOC_QUEUES;

    logic                       resp_fifo_empty_i;
    logic                       resp_fifo_read_o;
    logic [DATA_W-1:0]          resp_fifo_dout_addr_i;
    logic [MSG_ID_SIZE-1:0]     resp_fifo_dout_id_i;
    logic [NUM_RESP_QUEUES-1:0] rsp_val_o;
    logic [NUM_RESP_QUEUES-1:0] rsp_rdy_i;
    logic [DATA_W-1:0]          rsp_data_o [NUM_RESP_QUEUES];
    logic [15:0]                bad_id_cnt_o;

    // Arbiter side
    modport master (
        input  resp_fifo_empty_i,
        input  resp_fifo_dout_addr_i,
        input  resp_fifo_dout_id_i,
        input  rsp_rdy_i,
        output resp_fifo_read_o,
        output rsp_val_o,
        output rsp_data_o,
        output bad_id_cnt_o
    );

    // FIFO / consumer side
    modport slave (
        output resp_fifo_empty_i,
        output resp_fifo_dout_addr_i,
        output resp_fifo_dout_id_i,
        output rsp_rdy_i,
        input  resp_fifo_read_o,
        input  rsp_val_o,
        input  rsp_data_o,
        input  bad_id_cnt_o
    );
endinterface

// File: rtl/falafel_output_arbiter.sv
// Output arbiter: drains the allocator response FIFO into one-entry
// per-queue output slots. A full, non-draining slot stalls only when its
// own response is at the FIFO head; out-of-range IDs are dropped and
// counted with a saturating 16-bit counter.
module falafel_output_arbiter #(
    parameter int NUM_HEADER_QUEUES = 1,
    parameter int NUM_ALLOC_QUEUES  = 1,
    parameter int DATA_W            = 32,
    parameter int MSG_ID_SIZE       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    falafel_output_arbiter_if.master bus
);
    localparam int NUM_RESP_QUEUES = NUM_HEADER_QUEUES + NUM_ALLOC_QUEUES;
    localparam logic [MSG_ID_SIZE:0] NQ = (MSG_ID_SIZE+1)'(NUM_RESP_QUEUES);

    logic [NUM_RESP_QUEUES-1:0] vld_p0;
    logic [DATA_W-1:0]          data_p0 [NUM_RESP_QUEUES];
    logic [NUM_RESP_QUEUES-1:0] drain;
    logic [NUM_RESP_QUEUES-1:0] sel;
    logic [NUM_RESP_QUEUES-1:0] load;
    logic [15:0]                bad_cnt;
    logic                       id_ok;
    logic                       slot_ok;
    logic                       pop;
    logic                       drop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Route the FIFO head: pick its target slot, decide pop / drop / stall
    always_comb begin
        drain = '0;
        sel   = '0;
        id_ok = ({1'b0, bus.resp_fifo_dout_id_i} < NQ);
        for (int q = 0; q < NUM_RESP_QUEUES; q++) begin
            drain[q] = vld_p0[q] & bus.rsp_rdy_i[q];
            sel[q]   = id_ok && (bus.resp_fifo_dout_id_i == MSG_ID_SIZE'(q));
        end
        // Target slot can accept if empty or being emptied this cycle
        slot_ok = |(sel & (~vld_p0 | drain));
        // Gated by reset so the FIFO is never popped while held in reset
        pop     = rst_ni & ~bus.resp_fifo_empty_i & (~id_ok | slot_ok);
        drop    = pop & ~id_ok;
        load    = sel & {NUM_RESP_QUEUES{pop}};
    end

    // Output slots; a load in the same cycle as a drain keeps the slot full
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p0 <= '0;
            for (int q = 0; q < NUM_RESP_QUEUES; q++) begin
                data_p0[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_RESP_QUEUES; q++) begin
                if (load[q]) begin
                    vld_p0[q]  <= 1'b1;
                    data_p0[q] <= bus.resp_fifo_dout_addr_i;
                end else if (drain[q]) begin
                    vld_p0[q]  <= 1'b0;
                end
            end
        end
    end

    // Saturating count of responses dropped for an out-of-range ID
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bad_cnt <= '0;
        end else if (drop) begin
            bad_cnt <= sat_inc16(bad_cnt);
        end
    end

    assign bus.resp_fifo_read_o = pop;
    assign bus.rsp_val_o        = vld_p0;
    assign bus.rsp_data_o       = data_p0;
    assign bus.bad_id_cnt_o     = bad_cnt;

endmodule

// File: tb/tb_falafel_output_arbiter.sv
// Directed bench for falafel_output_arbiter: FWFT FIFO model, table of
// single-response vectors, and hand sequences for multi-cycle cases.
module tb_falafel_output_arbiter;
    localparam int DATA_W = 32;
    localparam int MSG_ID_SIZE = 4;
    localparam int NQ = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    falafel_output_arbiter_if #(
        .NUM_HEADER_QUEUES(1), .NUM_ALLOC_QUEUES(1),
        .DATA_W(DATA_W), .MSG_ID_SIZE(MSG_ID_SIZE)
    ) ifc ();

    falafel_output_arbiter #(
        .NUM_HEADER_QUEUES(1), .NUM_ALLOC_QUEUES(1),
        .DATA_W(DATA_W), .MSG_ID_SIZE(MSG_ID_SIZE)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifc.master)
    );

    // FWFT response FIFO model (never wraps within this run)
    logic [35:0] mem [0:131071];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int bad_reads = 0;

    assign ifc.resp_fifo_empty_i     = (rd_ptr == wr_ptr);
    assign ifc.resp_fifo_dout_addr_i = mem[rd_ptr[16:0]][31:0];
    assign ifc.resp_fifo_dout_id_i   = mem[rd_ptr[16:0]][35:32];

    always @(posedge clk) begin
        if (ifc.resp_fifo_read_o) begin
            if (rd_ptr == wr_ptr) bad_reads <= bad_reads + 1;
            else                  rd_ptr <= rd_ptr + 1;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic push(input logic [3:0] id, input logic [31:0] addr);
        mem[wr_ptr[16:0]] = {id, addr};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nedge(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [1:0]  exp_val;
        logic [15:0] exp_bad;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{id: 4'd0,  addr: 32'h0000_1000, exp_val: 2'b01, exp_bad: 16'd0};
        vecs[1] = '{id: 4'd1,  addr: 32'hDEAD_BEEF, exp_val: 2'b10, exp_bad: 16'd0};
        vecs[2] = '{id: 4'd0,  addr: 32'h0000_0000, exp_val: 2'b01, exp_bad: 16'd0};
        vecs[3] = '{id: 4'd2,  addr: 32'h0000_0055, exp_val: 2'b00, exp_bad: 16'd1};
        vecs[4] = '{id: 4'd15, addr: 32'h0000_0077, exp_val: 2'b00, exp_bad: 16'd2};
        vecs[5] = '{id: 4'd1,  addr: 32'hFFFF_FFFF, exp_val: 2'b10, exp_bad: 16'd2};

        ifc.rsp_rdy_i = 2'b00;
        #1 rst_n = 1'b0;

        // Reset: entry waiting in FIFO must not be popped while in reset
        nedge(1);
        push(4'd0, 32'h0000_1234);
        nedge(1);
        chk("rst_read", 32'(ifc.resp_fifo_read_o), 32'd0);
        chk("rst_val", 32'(ifc.rsp_val_o), 32'd0);
        chk("rst_data0", ifc.rsp_data_o[0], 32'd0);
        chk("rst_bad", 32'(ifc.bad_id_cnt_o), 32'd0);
        chk("rst_level", 32'(wr_ptr - rd_ptr), 32'd1);
        rst_n = 1'b1;
        ifc.rsp_rdy_i = 2'b11;
        nedge(1);
        chk("post_rst_val", 32'(ifc.rsp_val_o), 32'd1);
        chk("post_rst_data", ifc.rsp_data_o[0], 32'h1234);
        nedge(1);
        chk("post_rst_drain", 32'(ifc.rsp_val_o), 32'd0);

        // Table of single responses with consumers always ready
        foreach (vecs[i]) begin
            push(vecs[i].id, vecs[i].addr);
            nedge(1);
            chk("vec_val", 32'(ifc.rsp_val_o), 32'(vecs[i].exp_val));
            if (vecs[i].exp_val[0]) chk("vec_data0", ifc.rsp_data_o[0], vecs[i].addr);
            if (vecs[i].exp_val[1]) chk("vec_data1", ifc.rsp_data_o[1], vecs[i].addr);
            chk("vec_bad", 32'(ifc.bad_id_cnt_o), 32'(vecs[i].exp_bad));
            chk("vec_popped", 32'(wr_ptr - rd_ptr), 32'd0);
            nedge(1);
            chk("vec_drained", 32'(ifc.rsp_val_o), 32'd0);
        end

        // Back-to-back to the same queue: one response per cycle
        for (int k = 1; k <= 4; k++) push(4'd1, 32'(k * 16));
        for (int k = 1; k <= 4; k++) begin
            nedge(1);
            chk("b2b_val", 32'(ifc.rsp_val_o), 32'b10);
            chk("b2b_data", ifc.rsp_data_o[1], 32'(k * 16));
        end
        chk("b2b_level", 32'(wr_ptr - rd_ptr), 32'd0);
        nedge(1);
        chk("b2b_end", 32'(ifc.rsp_val_o), 32'd0);

        // Head-of-line stall and stall release without a bubble
        ifc.rsp_rdy_i = 2'b00;
        push(4'd0, 32'hA);
        push(4'd0, 32'hB);
        push(4'd1, 32'hC);
        nedge(1);
        chk("stall_val", 32'(ifc.rsp_val_o), 32'b01);
        chk("stall_data", ifc.rsp_data_o[0], 32'hA);
        nedge(3);
        chk("stall_hold_val", 32'(ifc.rsp_val_o), 32'b01);
        chk("stall_hold_data", ifc.rsp_data_o[0], 32'hA);
        chk("stall_read", 32'(ifc.resp_fifo_read_o), 32'd0);
        chk("stall_level", 32'(wr_ptr - rd_ptr), 32'd2);
        ifc.rsp_rdy_i = 2'b01;
        nedge(1);
        chk("release_val", 32'(ifc.rsp_val_o), 32'b01);
        chk("release_data", ifc.rsp_data_o[0], 32'hB);
        chk("release_level", 32'(wr_ptr - rd_ptr), 32'd1);
        nedge(1);
        chk("third_val", 32'(ifc.rsp_val_o), 32'b10);
        chk("third_data", ifc.rsp_data_o[1], 32'hC);
        ifc.rsp_rdy_i = 2'b11;
        nedge(1);
        chk("third_drain", 32'(ifc.rsp_val_o), 32'd0);

        // Bad-ID counter saturation
        for (int k = 0; k < 65540; k++) push(4'd3, 32'(k));
        nedge(1);
        chk("sat_first", 32'(ifc.bad_id_cnt_o), 32'd3);
        nedge(65545);
        chk("sat_val", 32'(ifc.bad_id_cnt_o), 32'hFFFF);
        chk("sat_level", 32'(wr_ptr - rd_ptr), 32'd0);
        chk("sat_no_rsp", 32'(ifc.rsp_val_o), 32'd0);

        // Asynchronous reset with a buffered, stalled response
        ifc.rsp_rdy_i = 2'b00;
        push(4'd0, 32'h1000);
        nedge(1);
        chk("mid_val", 32'(ifc.rsp_val_o), 32'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_val", 32'(ifc.rsp_val_o), 32'd0);
        chk("arst_data", ifc.rsp_data_o[0], 32'd0);
        chk("arst_bad", 32'(ifc.bad_id_cnt_o), 32'd0);
        nedge(2);
        rst_n = 1'b1;
        nedge(3);
        chk("after_rst_val", 32'(ifc.rsp_val_o), 32'd0);
        chk("after_rst_read", 32'(ifc.resp_fifo_read_o), 32'd0);

        chk("read_while_empty", 32'(bad_reads), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
